// File: rtl/online_qdigit_select.sv
// Online divider quotient-digit selection with on-the-fly conversion.
// Picks q_j in {-1,0,+1} from the residue estimate and builds the quotient.
module online_qdigit_select #(
  parameter int N      = 16,
  parameter int DELTA  = 3,
  parameter int THRESH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         w_valid,
  input  logic [5:0]   w_upper_shifted_plus,
  input  logic [5:0]   w_upper_shifted_minus,
  output logic         q_plus,
  output logic         q_minus,
  output logic         q_valid,
  output logic [N:0]   quotient,
  output logic         busy,
  output logic         done
);

  localparam int CMAX = (N > DELTA) ? N : DELTA;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic signed [6:0] P_TH  = 7'(THRESH);
  localparam logic signed [6:0] P_NTH = -P_TH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [N:0]      r_q;
  logic [N:0]      r_qm;
  logic [N:0]      r_quot;
  logic            r_qp;
  logic            r_qn;
  logic            r_qv;

  logic signed [6:0] w_est;
  logic            w_dp;
  logic            w_dn;
  logic            w_idle_like;
  logic            w_init_last;
  logic            w_run_last;
  logic [N:0]      w_q_nxt;
  logic [N:0]      w_qm_nxt;

  assign w_est = $signed({1'b0, w_upper_shifted_plus})
               - $signed({1'b0, w_upper_shifted_minus});
  assign w_dp  = (w_est >= P_TH);
  assign w_dn  = (w_est < P_NTH);

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_init_last = w_valid && (r_cnt == CW'(DELTA - 1));
  assign w_run_last  = w_valid && (r_cnt == CW'(N - 1));

  // OTFC: next Q/QM for the digit selected this cycle
  always_comb begin
    w_q_nxt  = r_q;
    w_qm_nxt = r_qm;
    unique case (1'b1)
      w_dp: begin
        w_q_nxt  = {r_q[N-1:0], 1'b1};
        w_qm_nxt = {r_q[N-1:0], 1'b0};
      end
      w_dn: begin
        w_q_nxt  = {r_qm[N-1:0], 1'b1};
        w_qm_nxt = {r_qm[N-1:0], 1'b0};
      end
      default: begin
        w_q_nxt  = {r_q[N-1:0], 1'b0};
        w_qm_nxt = {r_qm[N-1:0], 1'b1};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (DELTA == 0) ? S_RUN : S_INIT;
      end
      S_INIT: begin
        if (w_init_last) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_run_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (r_state == S_INIT) || (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Digit register, counter and OTFC accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_qm   <= '1;
      r_quot <= '0;
      r_qp   <= 1'b0;
      r_qn   <= 1'b0;
      r_qv   <= 1'b0;
    end else begin
      r_qp <= 1'b0;
      r_qn <= 1'b0;
      r_qv <= 1'b0;
      if (w_idle_like) begin
        if (start) begin
          r_cnt <= '0;
          r_q   <= '0;
          r_qm  <= '1;
        end
      end else if (r_state == S_INIT) begin
        if (w_valid) begin
          r_qv  <= 1'b1;
          r_cnt <= w_init_last ? '0 : r_cnt + 1'b1;
        end
      end else if (r_state == S_RUN) begin
        if (w_valid) begin
          r_qv  <= 1'b1;
          r_qp  <= w_dp;
          r_qn  <= w_dn;
          r_q   <= w_q_nxt;
          r_qm  <= w_qm_nxt;
          r_cnt <= w_run_last ? '0 : r_cnt + 1'b1;
          if (w_run_last) r_quot <= w_q_nxt;
        end
      end
    end
  end

  assign q_plus   = r_qp;
  assign q_minus  = r_qn;
  assign q_valid  = r_qv;
  assign quotient = r_quot;

endmodule

// File: tb/tb_online_qdigit_select.sv
// Bench for online_qdigit_select: arithmetic quotient model plus
// directed runs covering selection limits, online delay and handshakes.
module tb_online_qdigit_select;

  localparam int N      = 4;
  localparam int DELTA  = 3;
  localparam int THRESH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         w_valid = 1'b0;
  logic [5:0]   wp = '0;
  logic [5:0]   wm = '0;
  logic         q_plus;
  logic         q_minus;
  logic         q_valid;
  logic [N:0]   quotient;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_fail = 0;

  online_qdigit_select #(
    .N(N), .DELTA(DELTA), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .w_valid(w_valid),
    .w_upper_shifted_plus(wp),
    .w_upper_shifted_minus(wm),
    .q_plus(q_plus),
    .q_minus(q_minus),
    .q_valid(q_valid),
    .quotient(quotient),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 delay, 2 digits, 3 finished.
  // The quotient is the plain weighted sum of digits.
  int         ph = 0;
  int         mcnt = 0;
  int         acc = 0;
  int         d;
  logic       m_on = 1'b0;
  logic       e_qv = 1'b0;
  logic       e_qp = 1'b0;
  logic       e_qm = 1'b0;
  logic [N:0] e_quot = '0;

  function automatic int digit(input int p, input int m);
    int e;
    e = p - m;
    if (e >= THRESH) return 1;
    if (e < -THRESH) return -1;
    return 0;
  endfunction

  always @(posedge clk) begin
    e_qv = 1'b0;
    e_qp = 1'b0;
    e_qm = 1'b0;
    if (rst) begin
      m_on   = 1'b1;
      ph     = 0;
      mcnt   = 0;
      acc    = 0;
      e_quot = '0;
    end else begin
      case (ph)
        0, 3: if (start) begin
          ph   = (DELTA == 0) ? 2 : 1;
          mcnt = 0;
          acc  = 0;
        end
        1: if (w_valid) begin
          e_qv = 1'b1;
          mcnt++;
          if (mcnt == DELTA) begin
            ph   = 2;
            mcnt = 0;
          end
        end
        2: if (w_valid) begin
          d    = digit(int'(wp), int'(wm));
          e_qv = 1'b1;
          e_qp = (d > 0);
          e_qm = (d < 0);
          acc  = acc + d * (1 << (N - 1 - mcnt));
          mcnt++;
          if (mcnt == N) begin
            e_quot = acc[N:0];
            ph     = 3;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_on) begin
      chk("q_valid", 32'(q_valid), 32'(e_qv));
      chk("q_plus", 32'(q_plus), 32'(e_qp));
      chk("q_minus", 32'(q_minus), 32'(e_qm));
      chk("quotient", 32'(quotient), 32'(e_quot));
      chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
      chk("done", 32'(done), 32'(ph == 3));
    end
  end

  task automatic cyc(input logic s, input logic v,
                     input int p, input int m);
    start   = s;
    w_valid = v;
    wp      = 6'(p);
    wm      = 6'(m);
    @(negedge clk);
  endtask

  task automatic strobe(input int p, input int m);
    cyc(1'b0, 1'b1, p, m);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_quot", 32'(quotient), 32'd0);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    idle(1);
    strobe(63, 0);

    // Run A: online delay then +1,0,-1,+1 -> 7/16
    cyc(1'b1, 1'b0, 0, 0);
    chk("lit_init_busy", 32'(busy), 32'd1);
    strobe(63, 0);
    chk("lit_init_q0", 32'({q_valid, q_plus, q_minus}), 32'b100);
    strobe(63, 0);
    strobe(63, 0);
    chk("lit_init_q2", 32'({q_valid, q_plus, q_minus}), 32'b100);
    strobe(4, 0);
    chk("lit_th_p", 32'({q_valid, q_plus, q_minus}), 32'b110);
    strobe(3, 0);
    chk("lit_th_z", 32'({q_valid, q_plus, q_minus}), 32'b100);
    strobe(0, 5);
    chk("lit_th_n", 32'({q_valid, q_plus, q_minus}), 32'b101);
    strobe(63, 0);
    chk("lit_mixed_quot", 32'(quotient), 32'b00111);
    chk("lit_mixed_done", 32'({busy, done}), 32'b01);
    strobe(0, 63);
    chk("lit_done_noqv", 32'(q_valid), 32'd0);
    idle(2);

    // Run B: start with w_valid in DONE, gaps, start ignored mid-run
    cyc(1'b1, 1'b1, 63, 0);
    chk("lit_start_novalid", 32'(q_valid), 32'd0);
    chk("lit_retain_quot", 32'(quotient), 32'b00111);
    strobe(0, 0);
    idle(3);
    cyc(1'b1, 1'b0, 0, 0);
    strobe(0, 4);
    chk("lit_th_nz", 32'({q_valid, q_plus, q_minus}), 32'b100);
    idle(1);
    strobe(0, 0);
    strobe(0, 63);
    chk("lit_th_n63", 32'({q_valid, q_plus, q_minus}), 32'b101);
    cyc(1'b1, 1'b0, 0, 0);
    strobe(0, 5);
    idle(2);
    strobe(1, 6);
    chk("lit_retain_run", 32'(quotient), 32'b00111);
    strobe(0, 63);
    chk("lit_neg_quot", 32'(quotient), 32'b10001);
    idle(1);

    // Run C: reset in the middle of the digit phase
    cyc(1'b1, 1'b0, 0, 0);
    strobe(1, 1);
    strobe(1, 1);
    strobe(1, 1);
    strobe(63, 0);
    chk("lit_p63", 32'({q_valid, q_plus, q_minus}), 32'b110);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 63, 0);
    cyc(1'b0, 1'b1, 63, 0);
    rst = 1'b0;
    chk("lit_rst_quot", 32'(quotient), 32'd0);
    chk("lit_rst_flags", 32'({q_valid, busy, done}), 32'b000);
    idle(1);

    // Run D: clean run after reset, 8+4+0-1 = 11/16
    cyc(1'b1, 1'b0, 0, 0);
    strobe(5, 5);
    strobe(5, 5);
    strobe(5, 5);
    strobe(63, 0);
    strobe(20, 10);
    strobe(0, 0);
    strobe(2, 40);
    chk("lit_d_quot", 32'(quotient), 32'b01011);
    chk("lit_d_done", 32'({busy, done}), 32'b01);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/online_qdigit_select.md
Name: online_qdigit_select

Overview:
- Downstream neighbour of the residue-update stage in the online divider.
- Consumes the shifted upper residue bits (positive and negative signed-digit vectors) once per iteration and selects quotient digit q_j in {-1,0,+1}.
- Returns q_j to the residue datapath as a plus/minus bit pair.
- Assembles the final two's-complement quotient with on-the-fly conversion (OTFC), so no carry-propagate adder is needed at the end.

Parameters:
- N, 16, number of quotient digits produced after the online delay.
- DELTA, 3, online delay: number of initial w strobes consumed with q forced to 0 and not accumulated.
- THRESH, 4, selection threshold in LSB units of the residue estimate (4 = 1/2 with 3 fractional bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a division. Ignored unless in IDLE or DONE.
- w_valid  in  1  one-cycle strobe; w_upper_shifted_plus/minus valid this cycle.
- w_upper_shifted_plus  in  6  unsigned positive-digit upper residue bits.
- w_upper_shifted_minus  in  6  unsigned negative-digit upper residue bits.
- q_plus  out  1  selected digit, positive bit (q=+1 -> 1,0).
- q_minus  out  1  selected digit, negative bit (q=-1 -> 0,1; q=0 -> 0,0).
- q_valid  out  1  one-cycle strobe qualifying q_plus/q_minus.
- quotient  out  N+1  two's-complement quotient: sign bit plus N fractional bits, LSB weight 2^-N.
- busy  out  1  high in INIT and RUN.
- done  out  1  high while in DONE.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. q_plus=q_minus=q_valid=0, busy=done=0, quotient=0. Internal Q=0, QM=all ones, counter=0. Applies mid-operation with no partial result retained; rst overrides a simultaneous start or w_valid.
- Estimate: est = {1'b0,plus} - {1'b0,minus}, 7-bit signed, range -63..+63, no overflow.
- Selection: q=+1 if est >= THRESH; q=-1 if est < -THRESH; else q=0. Boundaries: est=+THRESH -> +1; est=-THRESH -> 0.
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE --start--> INIT. On entry, clear counter and set Q=0, QM=all ones.
  - INIT: each w_valid increments counter and emits q_valid with q=0 (plus=minus=0) one cycle later. Nothing is accumulated. After the DELTA-th strobe: counter=0, go to RUN. If DELTA=0, start goes directly to RUN.
  - RUN: each w_valid emits the selected digit on q_plus/q_minus with q_valid one cycle later (latency 1, registered). OTFC updates in the same edge:
    - q=+1: Q<={Q[N-1:0],1}, QM<={Q[N-1:0],0}
    - q=0: Q<={Q[N-1:0],0}, QM<={QM[N-1:0],1}
    - q=-1: Q<={QM[N-1:0],1}, QM<={QM[N-1:0],0}
    - After the N-th digit: quotient<=new Q, go to DONE.
  - DONE: done=1; quotient holds. start -> INIT (re-init as from IDLE). w_valid is ignored; no q_valid.
- q_valid never asserts in IDLE or DONE. w_valid in IDLE is ignored.
- start during INIT/RUN is ignored. start coincident with w_valid in IDLE/DONE: the transition is taken and that w_valid is not counted.
- quotient changes only on entry to DONE, and is cleared only by rst; it is not cleared by start.
- Back-to-back w_valid on every cycle is supported; w_valid gaps of any length are tolerated in INIT/RUN.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN -> next cycle state IDLE, quotient=0, q_valid=0, busy=0, done=0; a subsequent start runs cleanly from INIT.
- Selection boundaries in RUN (THRESH=4): (plus,minus)=(4,0) -> q=+1; (3,0) -> 0; (0,4) -> 0; (0,5) -> -1; (63,0) -> +1; (0,63) -> -1. Each q_valid appears exactly 1 cycle after its w_valid.
- Online delay, DELTA=3: start, then 3 strobes with (63,0) -> three q_valid with plus=minus=0, no accumulation, busy=1 throughout.
- OTFC mixed, N=4, DELTA=3: RUN digits +1,0,-1,+1 -> quotient=5'b00111 (7/16), done=1, busy=0.
- OTFC all negative, N=4: digits -1,-1,-1,-1 -> quotient=5'b10001 (-15/16).
- Handshake: start pulse during RUN ignored; w_valid in DONE produces no q_valid; new start in DONE with concurrent w_valid -> INIT entered, strobe not counted; quotient retained until the next completion.
